// File: rtl/myproject_dense_pkg.sv
// Shared types and default widths for the dense-layer accumulate/requantize datapath.
package myproject_dense_pkg;

  // Frame sequencing states of the accumulator.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FINAL = 2'd2
  } state_e;

  // Default datapath widths shared by all dense layers.
  localparam int DEF_PROD_WIDTH = 26;
  localparam int DEF_ACC_WIDTH  = 32;
  localparam int DEF_OUT_WIDTH  = 16;
  localparam int DEF_OUT_SHIFT  = 10;

  // Beat counter width: the counter must be able to hold N_IN itself.
  function automatic int cnt_width(input int n_in);
    return (n_in < 1) ? 1 : $clog2(n_in + 1);
  endfunction

endpackage

// File: rtl/myproject_requant_sat.sv
// Combinational requantizer: round half toward +inf, arithmetic shift,
// saturate to the signed output range and optionally clamp negatives (ReLU).
module myproject_requant_sat #(
  parameter int ACC_WIDTH = 32,
  parameter int OUT_SHIFT = 10,
  parameter int OUT_WIDTH = 16,
  parameter int RELU      = 0
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        sat
);

  // One extra bit so the rounding add can never overflow.
  localparam int EXT_W = ACC_WIDTH + 1;

  localparam logic signed [EXT_W-1:0] HALF    = EXT_W'(64'sd1 <<< (OUT_SHIFT - 1));
  localparam logic signed [EXT_W-1:0] OUT_MAX = EXT_W'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [EXT_W-1:0] OUT_MIN = ~OUT_MAX;

  logic signed [EXT_W-1:0] acc_ext;
  logic signed [EXT_W-1:0] rounded;
  logic signed [EXT_W-1:0] shifted;

  // Round, shift, saturate, then ReLU; the sat flag reflects clamping only.
  always_comb begin
    acc_ext  = EXT_W'(acc);
    rounded  = acc_ext + HALF;
    shifted  = rounded >>> OUT_SHIFT;
    sat      = 1'b0;
    out_data = shifted[OUT_WIDTH-1:0];
    if (shifted > OUT_MAX) begin
      out_data = OUT_MAX[OUT_WIDTH-1:0];
      sat      = 1'b1;
    end else if (shifted < OUT_MIN) begin
      out_data = OUT_MIN[OUT_WIDTH-1:0];
      sat      = 1'b1;
    end
    if ((RELU != 0) && out_data[OUT_WIDTH-1]) begin
      out_data = '0;
    end
  end

endmodule

// File: rtl/myproject_dense_acc_26_16.sv
// Dense-layer output neuron: bias-seeded accumulation of N_IN signed products,
// requantization and a single-entry valid/ready output register.
module myproject_dense_acc_26_16
  import myproject_dense_pkg::*;
#(
  parameter int N_IN       = 16,
  parameter int PROD_WIDTH = DEF_PROD_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int OUT_SHIFT  = DEF_OUT_SHIFT,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int RELU       = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         prod_valid,
  output logic                         prod_ready,
  input  logic signed [PROD_WIDTH-1:0] prod_data,
  input  logic                         prod_last,
  input  logic signed [PROD_WIDTH-1:0] bias,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic                         out_sat,
  output logic                         cnt_err
);

  localparam int CW = cnt_width(N_IN);

  state_e                        state_q, state_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic        [CW-1:0]          cnt_q, cnt_d;
  logic                          out_valid_q, out_valid_d;
  logic signed [OUT_WIDTH-1:0]   out_data_q, out_data_d;
  logic                          out_sat_q, out_sat_d;
  logic                          cnt_err_q, cnt_err_d;

  logic signed [ACC_WIDTH-1:0]   prod_ext;
  logic signed [ACC_WIDTH-1:0]   bias_ext;
  logic signed [OUT_WIDTH-1:0]   rq_data;
  logic                          rq_sat;
  logic                          accept;
  logic                          out_free;

  myproject_requant_sat #(
    .ACC_WIDTH(ACC_WIDTH),
    .OUT_SHIFT(OUT_SHIFT),
    .OUT_WIDTH(OUT_WIDTH),
    .RELU     (RELU)
  ) u_requant (
    .acc     (acc_q),
    .out_data(rq_data),
    .sat     (rq_sat)
  );

  // Next-state, accumulator, frame-length check and output register loading.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    cnt_err_d   = cnt_err_q;

    prod_ready = (state_q != FINAL);
    accept     = prod_valid && prod_ready;
    out_free   = !out_valid_q || out_ready;
    prod_ext   = ACC_WIDTH'(prod_data);
    bias_ext   = ACC_WIDTH'(bias);

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d = bias_ext + prod_ext;
          cnt_d = CW'(1);
          if (prod_last) begin
            if (N_IN != 1) cnt_err_d = 1'b1;
            state_d = FINAL;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = acc_q + prod_ext;
          if (cnt_q != CW'(N_IN)) cnt_d = cnt_q + CW'(1);
          if (prod_last) begin
            if ((int'(cnt_q) + 1) != N_IN) cnt_err_d = 1'b1;
            state_d = FINAL;
          end else if (cnt_q == CW'(N_IN)) begin
            cnt_err_d = 1'b1;
          end
        end
      end
      FINAL: begin
        if (out_free) begin
          out_data_d  = rq_data;
          out_sat_d   = rq_sat;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial sum and pending output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      cnt_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      cnt_err_q   <= cnt_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign cnt_err   = cnt_err_q;

endmodule

// File: tb/tb_myproject_dense_acc_26_16.sv
// Directed bench for the dense accumulator: three instances cover N_IN=4,
// N_IN=1 and a ReLU variant, all sharing data/bias/last/out_ready and reset.
module tb_myproject_dense_acc_26_16;

  logic clk;
  logic reset;
  logic signed [25:0] prod_data;
  logic signed [25:0] bias;
  logic prod_last;
  logic out_ready;

  logic v_n4, v_n1, v_r4;
  logic rdy_n4, rdy_n1, rdy_r4;
  logic ov_n4, ov_n1, ov_r4;
  logic signed [15:0] od_n4, od_n1, od_r4;
  logic os_n4, os_n1, os_r4;
  logic ce_n4, ce_n1, ce_r4;

  int checks = 0;
  int errors = 0;

  myproject_dense_acc_26_16 #(.N_IN(4), .RELU(0)) u_n4 (
    .clk(clk), .reset(reset), .prod_valid(v_n4), .prod_ready(rdy_n4),
    .prod_data(prod_data), .prod_last(prod_last), .bias(bias),
    .out_valid(ov_n4), .out_ready(out_ready), .out_data(od_n4),
    .out_sat(os_n4), .cnt_err(ce_n4));

  myproject_dense_acc_26_16 #(.N_IN(1), .RELU(0)) u_n1 (
    .clk(clk), .reset(reset), .prod_valid(v_n1), .prod_ready(rdy_n1),
    .prod_data(prod_data), .prod_last(prod_last), .bias(bias),
    .out_valid(ov_n1), .out_ready(out_ready), .out_data(od_n1),
    .out_sat(os_n1), .cnt_err(ce_n1));

  myproject_dense_acc_26_16 #(.N_IN(4), .RELU(1)) u_r4 (
    .clk(clk), .reset(reset), .prod_valid(v_r4), .prod_ready(rdy_r4),
    .prod_data(prod_data), .prod_last(prod_last), .bias(bias),
    .out_valid(ov_r4), .out_ready(out_ready), .out_data(od_r4),
    .out_sat(os_r4), .cnt_err(ce_r4));

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Counts one comparison and reports it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic signed [31:0] act,
                             input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Presents one beat to the selected instance (0=n4, 1=n1, 2=relu) for one edge.
  task automatic applyStimulus(input int sel, input int data, input logic last, input int b);
    prod_data = 26'(data);
    prod_last = last;
    bias      = 26'(b);
    case (sel)
      0:       v_n4 = 1'b1;
      1:       v_n1 = 1'b1;
      default: v_r4 = 1'b1;
    endcase
    @(posedge clk);
    @(negedge clk);
    v_n4 = 1'b0; v_n1 = 1'b0; v_r4 = 1'b0;
    prod_last = 1'b0;
  endtask

  // Four-beat frame with last on the fourth beat.
  task automatic sendFrame4(input int sel, input int b, input int p0, input int p1,
                            input int p2, input int p3);
    applyStimulus(sel, p0, 1'b0, b);
    applyStimulus(sel, p1, 1'b0, b);
    applyStimulus(sel, p2, 1'b0, b);
    applyStimulus(sel, p3, 1'b1, b);
  endtask

  int rp[6] = '{1536, -1536, 511, 512, -512, -513};
  int re[6] = '{2, -1, 0, 1, 0, -1};

  initial begin
    reset = 1'b0; prod_data = '0; bias = '0; prod_last = 1'b0; out_ready = 1'b1;
    v_n4 = 1'b0; v_n1 = 1'b0; v_r4 = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", ov_n4, 0);
    checkOutput("rst_out_data", od_n4, 0);
    checkOutput("rst_out_sat", os_n4, 0);
    checkOutput("rst_cnt_err", ce_n4, 0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_prod_ready", rdy_n4, 1);

    // Basic frame: 1024+2048-512+512 = 3072 -> 3, one bubble cycle.
    applyStimulus(0, 1024, 1'b0, 0);
    applyStimulus(0, 2048, 1'b0, 0);
    applyStimulus(0, -512, 1'b0, 0);
    checkOutput("basic_ready_before_last", rdy_n4, 1);
    applyStimulus(0, 512, 1'b1, 0);
    checkOutput("basic_bubble_ready", rdy_n4, 0);
    checkOutput("basic_valid_early", ov_n4, 0);
    @(negedge clk);
    checkOutput("basic_valid", ov_n4, 1);
    checkOutput("basic_data", od_n4, 3);
    checkOutput("basic_sat", os_n4, 0);
    checkOutput("basic_ready_after", rdy_n4, 1);
    @(negedge clk);
    checkOutput("basic_valid_cleared", ov_n4, 0);

    // Rounding corners on the single-beat instance.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, rp[i], 1'b1, 0);
      @(negedge clk);
      checkOutput($sformatf("round_%0d", rp[i]), od_n1, re[i]);
    end
    checkOutput("n1_cnt_err", ce_n1, 0);
    @(negedge clk);

    // Positive and negative saturation.
    sendFrame4(0, 0, 33554431, 33554431, 33554431, 33554431);
    @(negedge clk);
    checkOutput("sat_pos_data", od_n4, 32767);
    checkOutput("sat_pos_flag", os_n4, 1);
    @(negedge clk);
    sendFrame4(0, 0, -33554432, -33554432, -33554432, -33554432);
    @(negedge clk);
    checkOutput("sat_neg_data", od_n4, -32768);
    checkOutput("sat_neg_flag", os_n4, 1);
    @(negedge clk);

    // Sum -3072: ReLU instance clamps to 0, plain instance gives -3.
    sendFrame4(2, 0, -1024, -1024, -1024, 0);
    @(negedge clk);
    checkOutput("relu_valid", ov_r4, 1);
    checkOutput("relu_data", od_r4, 0);
    checkOutput("relu_sat", os_r4, 0);
    @(negedge clk);
    sendFrame4(0, 0, -1024, -1024, -1024, 0);
    @(negedge clk);
    checkOutput("neg_data", od_n4, -3);
    checkOutput("neg_sat", os_n4, 0);
    @(negedge clk);

    // Backpressure: first result 8 held while second frame (bias 1024 -> 4) waits.
    out_ready = 1'b0;
    sendFrame4(0, 0, 2048, 2048, 2048, 2048);
    @(negedge clk);
    checkOutput("bp_first_valid", ov_n4, 1);
    checkOutput("bp_first_data", od_n4, 8);
    sendFrame4(0, 1024, 1024, 2048, -512, 512);
    for (int i = 0; i < 6; i++) begin
      checkOutput("bp_hold_ready", rdy_n4, 0);
      checkOutput("bp_hold_valid", ov_n4, 1);
      checkOutput("bp_hold_data", od_n4, 8);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_second_valid", ov_n4, 1);
    checkOutput("bp_second_data", od_n4, 4);
    checkOutput("bp_second_ready", rdy_n4, 1);
    @(negedge clk);
    checkOutput("bp_drained", ov_n4, 0);
    sendFrame4(0, 100, 1024, 2048, -512, 512);
    @(negedge clk);
    checkOutput("bias100_data", od_n4, 3);
    @(negedge clk);

    // Short frame sets the sticky error; a later good frame keeps it.
    checkOutput("err_clear_before", ce_n4, 0);
    applyStimulus(0, 1024, 1'b0, 0);
    applyStimulus(0, 1024, 1'b0, 0);
    applyStimulus(0, 1024, 1'b1, 0);
    checkOutput("err_short_flag", ce_n4, 1);
    @(negedge clk);
    checkOutput("err_short_data", od_n4, 3);
    @(negedge clk);
    sendFrame4(0, 0, 1024, 2048, -512, 512);
    @(negedge clk);
    checkOutput("err_good_data", od_n4, 3);
    checkOutput("err_sticky", ce_n4, 1);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("err_reset_clear", ce_n4, 0);
    reset = 1'b1;
    @(negedge clk);

    // Long frame: fifth beat without last flags the error.
    for (int i = 0; i < 4; i++) applyStimulus(0, 1024, 1'b0, 0);
    checkOutput("long_no_err_yet", ce_n4, 0);
    applyStimulus(0, 1024, 1'b0, 0);
    checkOutput("long_err", ce_n4, 1);
    applyStimulus(0, 1024, 1'b1, 0);
    @(negedge clk);
    checkOutput("long_data", od_n4, 6);
    @(negedge clk);

    // Reset mid-frame with a result pending discards both.
    out_ready = 1'b0;
    sendFrame4(0, 0, 2048, 2048, 2048, 2048);
    @(negedge clk);
    checkOutput("mid_pending", ov_n4, 1);
    applyStimulus(0, 50000, 1'b0, 0);
    applyStimulus(0, 50000, 1'b0, 0);
    reset = 1'b0;
    #1;
    checkOutput("mid_async_valid", ov_n4, 0);
    checkOutput("mid_async_data", od_n4, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_valid_after", ov_n4, 0);
    checkOutput("mid_ready_after", rdy_n4, 1);
    out_ready = 1'b1;
    sendFrame4(0, 0, 1024, 2048, -512, 512);
    @(negedge clk);
    checkOutput("mid_fresh_valid", ov_n4, 1);
    checkOutput("mid_fresh_data", od_n4, 3);
    checkOutput("mid_fresh_err", ce_n4, 0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/myproject_dense_acc_26_16.md
Name: myproject_dense_acc_26_16

Overview:
Downstream consumer of the 16s x 10u -> 26-bit product stage in the dense-layer datapath. It accumulates N_IN signed products per output neuron and seeds the sum with a per-neuron bias. It then requantizes by a rounding arithmetic right shift, saturates to the layer output width and optionally applies ReLU. The result is presented on a valid/ready output to the next layer.

Parameters:
N_IN, 16, products per output neuron (frame length); must be >= 1
PROD_WIDTH, 26, signed product width from the multiplier stage
ACC_WIDTH, 32, accumulator width; must be >= PROD_WIDTH + clog2(N_IN)
OUT_SHIFT, 10, arithmetic right shift applied at requantization; must be >= 1
OUT_WIDTH, 16, signed output width
RELU, 0, 1 = clamp negative results to 0 after saturation

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
prod_valid  in  1  product beat valid
prod_ready  out  1  block can accept a product beat
prod_data  in  PROD_WIDTH  signed product
prod_last  in  1  final beat of the frame
bias  in  PROD_WIDTH  signed bias in product scale, sampled on the first beat of a frame
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  OUT_WIDTH  signed requantized result
out_sat  out  1  out_data was saturated (travels with out_data)
cnt_err  out  1  sticky frame-length error flag

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, acc=0, cnt=0, out_valid=0, out_data=0, out_sat=0, cnt_err=0. prod_ready reads 1 once reset is released.
- Beat accept: prod_valid && prod_ready at the rising edge. prod_data and bias are sign-extended to ACC_WIDTH. The accumulator wraps modulo 2^ACC_WIDTH; there is no overflow detection in the accumulator.
- FSM IDLE: prod_ready=1. On accept: acc <= bias + prod_data, cnt <= 1. Go to FINAL if prod_last, else ACCUM.
- FSM ACCUM: prod_ready=1. On accept: acc <= acc + prod_data, cnt <= cnt+1 (saturating at N_IN). Go to FINAL on prod_last.
- FSM FINAL: prod_ready=0. When the output register is free (!out_valid || out_ready):
  - out_data <= requant(acc), out_sat <= sat flag, out_valid <= 1.
  - Go to IDLE.
  Otherwise stay in FINAL and hold acc.
- requant(acc): r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, computed in ACC_WIDTH+1 bits so the rounding add cannot overflow.
  - Round half toward +inf.
  - Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; set sat if clamped.
  - If RELU=1 and the result is negative, output 0. sat is unaffected by ReLU.
- Latency: last beat accepted at edge t -> out_valid=1 after edge t+1 if the output register is free. One bubble cycle per frame: prod_ready=0 in FINAL.
- out_valid clears on out_ready unless FINAL loads a new result in the same cycle, in which case the new data replaces the old with out_valid held at 1. out_data and out_sat are stable while out_valid && !out_ready.
- cnt_err (sticky, cleared only by reset) is set on either condition:
  - prod_last is accepted with cnt+1 != N_IN;
  - a beat without prod_last is accepted when cnt == N_IN.
  The frame still completes normally with whatever was accumulated.
- prod_valid=0 in any state: no state change. Bias is ignored except on IDLE accepts.
- Reset mid-frame: the partial sum and any pending output are discarded.

Decomposition:
- Package myproject_dense_pkg holds:
  - state enum {IDLE, ACCUM, FINAL};
  - default width constants (PROD_WIDTH, ACC_WIDTH, OUT_WIDTH, OUT_SHIFT);
  - a clog2-based counter-width constant function.
- Sub-module myproject_requant_sat: purely combinational round / shift / saturate / ReLU. Inputs acc; outputs out_data and sat; parameters ACC_WIDTH, OUT_SHIFT, OUT_WIDTH, RELU. It is reused by the other dense layers.

Test Plan:
- N_IN=4, bias=0, products 1024, 2048, -512, 512, out_ready=1 -> out_data=3, out_sat=0, out_valid one cycle after the last beat, prod_ready=0 for exactly 1 cycle.
- Rounding: N_IN=1, bias=0, prod=1536 -> out_data=2. prod=-1536 -> out_data=-1. prod=511 -> 0. prod=512 -> 1.
- Saturation and ReLU: four beats of 33554431 -> out_data=32767, out_sat=1. RELU=1 with products summing to -3072 -> out_data=0, out_sat=0. RELU=0, same sum -> -3.
- Backpressure: out_ready=0 for 6 cycles while a second frame completes -> FSM holds FINAL, prod_ready=0. The first result stays stable until accepted; the second result is presented on the next cycle with its correct value (bias=100 adds +0 after the shift; bias=1024 adds +1).
- Count error: N_IN=4, prod_last on beat 3 -> result emitted and cnt_err=1, stays 1 through later good frames until reset. Five beats without last -> cnt_err=1.
- Reset mid-frame: assert reset after 2 beats -> out_valid=0, prod_ready=1 after release. A fresh 4-beat frame gives the exact expected sum, with no residue from the aborted frame.
